// File: rtl/mem_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_sram_pkg
// Brief  : Shared state encoding and sizing helper for the SRAM bank.
// Rev    : 1.0
// ============================================================================
package mem_sram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Index width for a storage of n words; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module : mem_lat_pipe
// Brief  : Fixed-depth shift register carrying response valid/data/error.
// Rev    : 1.0
// ============================================================================
module mem_lat_pipe #(
    parameter int unsigned Depth     = 1,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 err_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 err_o
);

    logic [Depth-1:0]                r_valid;
    logic [Depth-1:0][DataWidth-1:0] r_data;
    logic [Depth-1:0]                r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_data  <= '0;
            r_err   <= '0;
        end else begin
            r_valid[0] <= valid_i;
            r_data[0]  <= data_i;
            r_err[0]   <= err_i;
            for (int s = 1; s < int'(Depth); s++) begin
                r_valid[s] <= r_valid[s-1];
                r_data[s]  <= r_data[s-1];
                r_err[s]   <= r_err[s-1];
            end
        end
    end

    assign valid_o = r_valid[Depth-1];
    assign data_o  = r_data[Depth-1];
    assign err_o   = r_err[Depth-1];

endmodule
`default_nettype wire

// File: rtl/mem_sram_bank.sv
`default_nettype none
// ============================================================================
// Module : mem_sram_bank
// Brief  : Single-port byte-writable SRAM bank with fixed read latency,
//          range checking and optional zero-fill after reset.
// Rev    : 1.0
// ============================================================================
module mem_sram_bank
    import mem_sram_pkg::*;
#(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned NumWords    = 1024,
    parameter int unsigned ReadLatency = 1,
    parameter int unsigned InitZero    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [DataWidth/8-1:0] mem_strb_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_err_o,
    output logic                   busy_o
);

    localparam int unsigned c_bytes    = DataWidth / 8;
    localparam int unsigned c_off_bits = $clog2(c_bytes);
    localparam int unsigned c_idx_w    = idx_width(NumWords);
    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(NumWords - 1);
    localparam logic [AddrWidth:0]  c_num_words = (AddrWidth + 1)'(NumWords);
    localparam state_e c_reset_state = (InitZero != 0) ? INIT : RUN;

    state_e               r_state;
    state_e               w_state_next;
    logic [c_idx_w-1:0]   r_init_cnt;
    logic                 w_init_we;

    logic [DataWidth-1:0] r_mem [NumWords];

    logic [AddrWidth-1:0] w_word_idx;
    logic [c_idx_w-1:0]   w_idx;
    logic                 w_in_range;
    logic                 w_wr_en;
    logic [DataWidth-1:0] w_rsp_data;
    logic                 w_rsp_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_reset_state;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_init_we) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_init_we    = 1'b0;
        case (r_state)
            INIT: begin
                w_init_we = 1'b1;
                if (r_init_cnt == c_last_idx) begin
                    w_state_next = RUN;
                end
            end
            RUN:     w_state_next = RUN;
            default: w_state_next = c_reset_state;
        endcase
    end

    assign busy_o     = (r_state == INIT);
    assign mem_gnt_o  = mem_req_i && (r_state == RUN) && !rst_i;

    // Full-width compare so addresses beyond the array never alias into it.
    assign w_word_idx = mem_addr_i >> c_off_bits;
    assign w_in_range = ({1'b0, w_word_idx} < c_num_words);
    assign w_idx      = w_word_idx[c_idx_w-1:0];
    assign w_wr_en    = mem_gnt_o && mem_we_i && w_in_range;

    always_ff @(posedge clk_i) begin
        if (w_init_we && !rst_i) begin
            r_mem[r_init_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < int'(c_bytes); b++) begin
                if (mem_strb_i[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Responses are zero unless they carry in-range read data.
    assign w_rsp_data = (mem_gnt_o && !mem_we_i && w_in_range) ? r_mem[w_idx] : '0;
    assign w_rsp_err  = mem_gnt_o && !w_in_range;

    mem_lat_pipe #(
        .Depth     (ReadLatency),
        .DataWidth (DataWidth)
    ) u_lat_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (mem_gnt_o),
        .data_i  (w_rsp_data),
        .err_i   (w_rsp_err),
        .valid_o (mem_rvalid_o),
        .data_o  (mem_rdata_o),
        .err_o   (mem_err_o)
    );

endmodule
`default_nettype wire

// File: doc/mem_sram_bank.md
MEM_SRAM_BANK -- requirements
Module: mem_sram_bank

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32, memory byte-address width.
REQ-002 The block SHALL have parameter DataWidth, default 32, word width; a multiple of 8.
REQ-003 The block SHALL have parameter NumWords, default 1024, storage depth; a power of two.
REQ-004 The block SHALL have parameter ReadLatency, default 1, grant-to-response cycles; legal range 1..4.
REQ-005 The block SHALL have parameter InitZero, default 1, zero-fill the storage after reset when 1.
REQ-006 The block SHALL have port clk_i, input, 1, the only clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-008 The block SHALL have port mem_req_i, input, 1, request valid.
REQ-009 The block SHALL have port mem_gnt_o, output, 1, request accepted this cycle.
REQ-010 The block SHALL have port mem_addr_i, input, AddrWidth, byte address.
REQ-011 The block SHALL have port mem_we_i, input, 1, write when 1, read when 0.
REQ-012 The block SHALL have port mem_strb_i, input, DataWidth/8, byte enables for writes.
REQ-013 The block SHALL have port mem_wdata_i, input, DataWidth, write data.
REQ-014 The block SHALL have port mem_rvalid_o, output, 1, response valid.
REQ-015 The block SHALL have port mem_rdata_o, output, DataWidth, read data.
REQ-016 The block SHALL have port mem_err_o, output, 1, out-of-range access; qualified by mem_rvalid_o.
REQ-017 The block SHALL have port busy_o, output, 1, zero-fill in progress.

Function
REQ-018 The FSM SHALL have states INIT and RUN; reset enters INIT if InitZero=1, else RUN.
REQ-019 In INIT, a word counter SHALL write zero to word 0..NumWords-1, one word per cycle, then go to RUN; the cycle count is exactly NumWords.
REQ-020 mem_gnt_o SHALL equal mem_req_i AND (state==RUN), combinationally, with no other stall source.
REQ-021 busy_o SHALL be 1 exactly while in INIT.
REQ-022 Word index SHALL be mem_addr_i >> log2(DataWidth/8); sub-word address bits SHALL be ignored.
REQ-023 An index >= NumWords SHALL be out of range: no storage update, response rdata 0, mem_err_o=1.
REQ-024 A granted write SHALL update only bytes whose strb bit is 1, visible to a read granted the next cycle.
REQ-025 A granted write with strb all-zero SHALL leave storage unchanged and still produce a response.
REQ-026 Every granted request SHALL produce exactly one response exactly ReadLatency cycles after its grant cycle, in order.
REQ-027 The response SHALL carry rdata = stored word for in-range reads and 0 for writes; mem_err_o SHALL be 0 when in range.
REQ-028 Back-to-back grants SHALL produce back-to-back responses; there is no response back-pressure.
REQ-029 mem_rdata_o and mem_err_o SHALL be 0 whenever mem_rvalid_o is 0.

Reset
REQ-030 Asserting rst_i in any cycle, including during INIT or with responses in flight, SHALL clear the latency pipeline, so that mem_rvalid_o=0, mem_rdata_o=0, and mem_err_o=0 on the next cycle.
REQ-031 While rst_i is asserted, mem_gnt_o SHALL be 0.
REQ-032 After rst_i is released, busy_o SHALL equal InitZero, and the init counter SHALL restart at 0.
REQ-033 Storage contents SHALL be unaffected by reset itself; they are cleared only by INIT.

Structure
REQ-034 Package mem_sram_pkg SHALL hold the state enum (INIT, RUN) and an index-width helper function.
REQ-035 The latency shift register for valid/rdata/err SHALL be the sub-module mem_lat_pipe, with parameters Depth and DataWidth.
REQ-036 Storage SHALL be a single inferred array with a per-byte write enable.

Verification
REQ-037 Reset with InitZero=1: busy_o=1 for exactly 1024 cycles, and mem_gnt_o=0 throughout; then a read of 0x0000_0FFC returns 0.
REQ-038 Write 0xDEADBEEF to 0x10 with strb=0xF, then write 0x000000AA with strb=0x1, then read 0x10 -> rdata 0xDEADBEAA after ReadLatency cycles.
REQ-039 With ReadLatency=3, four consecutive grants (W,R,R,W) -> four consecutive rvalid pulses starting 3 cycles later; write responses have rdata=0.
REQ-040 Read 0x0000_1000 with NumWords=1024 -> rvalid with err=1 and rdata=0; a following read of 0x0 is unaffected.
REQ-041 Assert rst_i for 1 cycle with 2 responses in flight -> mem_rvalid_o=0 next cycle, neither response emitted, and INIT restarts.
